float_multiplier_param: RTL and testbench
=========================================

// Module: float_multiplier_param
// PURPOSE
//   Parametrised floating-point multiplier (sign | EXP_W exponent | MAN_W mantissa, hidden one).
//   Generalises the fixed e4m3/bf16 multipliers: any format, valid/ready handshake on both sides,
//   saturation and flush-to-zero with status flags, optional round-to-nearest-even.
//   Sits in the arithmetic datapath between operand staging and accumulate/store logic.
// PARAMETERS
//   EXP_W   4                        exponent width; 4 = e4m3, 8 = bf16
//   MAN_W   3                        stored mantissa width; 3 = e4m3, 7 = bf16
//   BIAS    (1<<(EXP_W-1))-1         exponent bias; 7 for e4m3, 127 for bf16
//   W       1+EXP_W+MAN_W            total word width (localparam, derived)
// PORTS
//   clock      in   1  rising-edge clock
//   reset      in   1  asynchronous, active-low reset
//   a          in   W  operand A, sampled on input handshake
//   b          in   W  operand B, sampled on input handshake
//   in_valid   in   1  operands present
//   in_ready   out  1  block can accept operands (high only in IDLE)
//   y          out  W  product; stable while out_valid is high
//   out_valid  out  1  y and flags valid
//   out_ready  in   1  consumer accepts y
//   ovf        out  1  result saturated to max finite magnitude
//   unf        out  1  result flushed to zero by exponent underflow
// BEHAVIOUR
//   Reset (reset low, async): state=IDLE, in_ready=1, out_valid=0, y=0, ovf=0, unf=0.
//   Reset mid-operation aborts the op; nothing is emitted; in_ready=1 on the first edge after release.
//   FSM: IDLE -(in_valid&in_ready)-> MUL -> NORM -> ROUND -> DONE -(out_ready)-> IDLE.
//   Fixed latency: accept at edge N -> out_valid high after edge N+3, for every operand class.
//   IDLE: register a,b. MUL: p = {1,ma}*{1,mb} (2*MAN_W+2 bits);
//     e = ea+eb-BIAS in signed EXP_W+2 bits; s = sa^sb.
//   NORM: if p MSB set, shift p right 1 and e+=1 (p is in [1,4), so at most one shift).
//   ROUND: take MAN_W bits below the hidden one; rest is guard/round/sticky (see CONFIGURATION).
//     If the round carry makes the mantissa all-zero with overflow: e+=1 and mantissa=0.
//   Result classes, in priority order:
//     Either operand exponent==0 (zero or denormal) -> y={s,0...}, ovf=0, unf=0.
//     e <= 0 -> y={s,0...}, unf=1.
//     e > 2^EXP_W-1 -> y={s,all-ones exp,all-ones man}, ovf=1.
//       The all-ones exponent is a finite encoding; there is no inf/NaN.
//     Otherwise -> y={s,e[EXP_W-1:0],mantissa}.
//   DONE: out_valid=1; y/ovf/unf held until out_ready.
//     Out handshake returns to IDLE; in_ready rises the next cycle (no overlap; throughput 1 per 5 cycles).
//   in_valid while busy is ignored (in_ready=0); the producer holds it.
//   out_ready high before DONE has no effect.
// CONFIGURATION
//   ROUND_NEAREST_EN defined: round-to-nearest-even on guard/round/sticky.
//     Ties go to an even LSB; a carry out of the mantissa renormalises as described above.
//   ROUND_NEAREST_EN undefined: truncate (round toward zero); ROUND is a pass-through state.
//     Latency is unchanged (3).
// TESTING (defaults EXP_W=4, MAN_W=3)
//   Reset: reset low mid-MUL with a=0x3C,b=0x3C -> out_valid stays 0, in_ready=1 after release.
//   Basic: 0x38*0x38 -> y=0x38 at N+3; 0x3C*0x3C -> 0x41; 0xB8*0x38 -> 0xB8; ovf=unf=0.
//   Rounding: 0x3D*0x3D -> 0x43 with ROUND_NEAREST_EN, 0x42 without.
//   Saturate/flush: 0x77*0x77 -> 0x7F, ovf=1; 0x08*0x08 -> 0x00, unf=1; 0x80*0x3C -> 0x80, flags 0.
//   Backpressure: out_ready low 6 cycles after DONE -> y,out_valid held, in_ready=0;
//     out_ready high -> IDLE next edge.
//   Back-to-back: in_valid held with 4 operand pairs -> 4 results in order, each exactly 5 cycles apart.

Source files
------------

// File: rtl/float_multiplier_param.sv
// ---------------------------------------------------------------------------
// float_multiplier_param
//
// Parametrised floating-point multiplier for words laid out as
// {sign, EXP_W exponent, MAN_W mantissa} with a hidden leading one.
// One operation is in flight at a time: IDLE -> MUL -> NORM -> ROUND -> DONE,
// so a result appears exactly three edges after the input handshake and
// stays on y until the consumer takes it.
//
// Result classes, in priority order:
//   - either operand exponent zero -> signed zero, no flags
//   - exponent underflow (e <= 0)  -> signed zero, unf=1
//   - exponent overflow            -> signed max finite magnitude, ovf=1
//   - otherwise                    -> normal packed result
// The all-ones exponent is an ordinary finite encoding (no inf/NaN).
//
// Compile-time option:
//   ROUND_NEAREST_EN  defined   : round-to-nearest-even on guard/round/sticky
//                     undefined : truncate toward zero (ROUND just packs)
//
// Ports:
//   clock      in   1  rising-edge clock
//   reset      in   1  asynchronous active-low reset
//   a, b       in   W  operands, sampled on in_valid & in_ready
//   in_valid   in   1  operands present
//   in_ready   out  1  high only in IDLE
//   y          out  W  product, held while out_valid is high
//   out_valid  out  1  y/ovf/unf valid
//   out_ready  in   1  consumer accepts y
//   ovf        out  1  result saturated to max finite magnitude
//   unf        out  1  result flushed to zero by exponent underflow
// ---------------------------------------------------------------------------
module float_multiplier_param #(
    parameter int EXP_W = 4,
    parameter int MAN_W = 3,
    parameter int BIAS  = (1 << (EXP_W - 1)) - 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [EXP_W+MAN_W:0]       a,
    input  logic [EXP_W+MAN_W:0]       b,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [EXP_W+MAN_W:0]       y,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       ovf,
    output logic                       unf
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;   // full product of two (MAN_W+1)-bit significands
    localparam int EW = EXP_W + 2;       // signed working exponent, room for under/overflow

    localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
    localparam logic signed [EW-1:0] EZERO  = '0;
    localparam logic signed [EW-1:0] EONE   = EW'(1);
    localparam logic signed [EW-1:0] EMAX   = EW'((1 << EXP_W) - 1);

`ifdef ROUND_NEAREST_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, MUL, NORM, ROUND, DONE} state_t;

    state_t                 state_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic [W-1:0]           y_q;
    logic                   ovf_q;
    logic                   unf_q;

    logic [W-1:0]           a_q;
    logic [W-1:0]           b_q;
    logic [PW-1:0]          prod_q;
    logic [PW-3:0]          frac_q;    // fraction bits below the hidden one after NORM
    logic                   sticky_q;  // bit lost by the normalising shift
    logic signed [EW-1:0]   exp_q;
    logic                   sign_q;
    logic                   zero_q;

    logic [PW-1:0]          ma_ext;
    logic [PW-1:0]          mb_ext;
    logic signed [EW-1:0]   ea_s;
    logic signed [EW-1:0]   eb_s;
    logic [MAN_W:0]         rnd;
    logic signed [EW-1:0]   exp_r;
    logic [W+1:0]           res;
    logic [W-1:0]           y_d;
    logic                   ovf_d;
    logic                   unf_d;

    // Returns {carry, mantissa}; carry set means the rounded mantissa wrapped to zero.
    function automatic logic [MAN_W:0] round_mant(input logic [PW-3:0] f, input logic st);
        logic [MAN_W-1:0] m;
        logic [MAN_W:0]   rest;
        logic             g;
        logic             s;
        logic             up;
        m    = f[PW-3:MAN_W];
        rest = {f[MAN_W-1:0], st};
        g    = rest[MAN_W];
        s    = |rest[MAN_W-1:0];
        up   = RNE & g & (s | m[0]);
        return {1'b0, m} + {{MAN_W{1'b0}}, up};
    endfunction

    // Returns {ovf, unf, y} after class selection and saturation/flush.
    function automatic logic [W+1:0] pack_result(input logic s, input logic z,
                                                 input logic signed [EW-1:0] e,
                                                 input logic [MAN_W-1:0] m);
        if (z)
            return {2'b00, s, {(W-1){1'b0}}};
        else if (e <= EZERO)
            return {2'b01, s, {(W-1){1'b0}}};
        else if (e > EMAX)
            return {2'b10, s, {(W-1){1'b1}}};
        return {2'b00, s, e[EXP_W-1:0], m};
    endfunction

    assign ma_ext = PW'({1'b1, a_q[MAN_W-1:0]});
    assign mb_ext = PW'({1'b1, b_q[MAN_W-1:0]});
    assign ea_s   = $signed(EW'(a_q[W-2:MAN_W]));
    assign eb_s   = $signed(EW'(b_q[W-2:MAN_W]));

    always_comb begin
        rnd   = round_mant(frac_q, sticky_q);
        exp_r = exp_q + $signed({{(EW-1){1'b0}}, rnd[MAN_W]});
        res   = pack_result(sign_q, zero_q, exp_r, rnd[MAN_W-1:0]);
        ovf_d = res[W+1];
        unf_d = res[W];
        y_d   = res[W-1:0];
    end

    // Datapath registers: only one operation is in flight, so each stage
    // overwrites the shared registers in the state that owns them.
    always_ff @(posedge clock) begin
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_q <= a;
                    b_q <= b;
                end
            end
            // MUL -> NORM
            MUL: begin
                prod_q <= ma_ext * mb_ext;
                exp_q  <= ea_s + eb_s - BIAS_S;
                sign_q <= a_q[W-1] ^ b_q[W-1];
                zero_q <= (a_q[W-2:MAN_W] == '0) || (b_q[W-2:MAN_W] == '0);
            end
            // NORM -> ROUND: product lies in [1,4), so at most one right shift
            NORM: begin
                if (prod_q[PW-1]) begin
                    frac_q   <= prod_q[PW-2:1];
                    sticky_q <= prod_q[0];
                    exp_q    <= exp_q + EONE;
                end else begin
                    frac_q   <= prod_q[PW-3:0];
                    sticky_q <= 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q    <= MUL;
                        in_ready_q <= 1'b0;
                    end
                end
                MUL:  state_q <= NORM;
                NORM: state_q <= ROUND;
                // ROUND -> DONE: result is latched once and held for the consumer
                ROUND: begin
                    state_q     <= DONE;
                    out_valid_q <= 1'b1;
                    y_q         <= y_d;
                    ovf_q       <= ovf_d;
                    unf_q       <= unf_d;
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;

endmodule

// File: tb/tb_float_multiplier_param.sv
module tb_float_multiplier_param;

    logic       clock;
    logic       reset;
    logic [7:0] a;
    logic [7:0] b;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] y;
    logic       out_valid;
    logic       out_ready;
    logic       ovf;
    logic       unf;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef ROUND_NEAREST_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    float_multiplier_param #(.EXP_W(4), .MAN_W(3)) dut (
        .clock(clock), .reset(reset), .a(a), .b(b),
        .in_valid(in_valid), .in_ready(in_ready),
        .y(y), .out_valid(out_valid), .out_ready(out_ready),
        .ovf(ovf), .unf(unf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model for e4m3: real-valued significand product, normalised
    // into [1,2), scaled to 3 fraction bits, then rounded by value.
    // Returns {ovf, unf, y}.
    function automatic logic [9:0] model(input logic [7:0] xa, input logic [7:0] xb);
        int  ea, eb, e, q;
        logic s;
        real v, sc, fr;
        logic [3:0] ebits;
        logic [2:0] mbits;
        ea = int'(xa[6:3]);
        eb = int'(xb[6:3]);
        s  = xa[7] ^ xb[7];
        if (ea == 0 || eb == 0) return {2'b00, s, 7'h00};
        v = (real'(8 + int'(xa[2:0])) / 8.0) * (real'(8 + int'(xb[2:0])) / 8.0);
        e = ea + eb - 7;
        while (v >= 2.0) begin
            v = v / 2.0;
            e = e + 1;
        end
        sc = v * 8.0;
        q  = $rtoi(sc);
        fr = sc - real'(q);
        if (RNE && (fr > 0.5 || (fr == 0.5 && (q % 2) == 1))) q = q + 1;
        if (q == 16) begin
            q = 8;
            e = e + 1;
        end
        if (e <= 0) return {2'b01, s, 7'h00};
        if (e > 15) return {2'b10, s, 7'h7F};
        ebits = e[3:0];
        mbits = q[2:0];
        return {2'b00, s, ebits, mbits};
    endfunction

    // Drives one operation and returns the result and the accept-to-valid latency
    // (-1 if the handshake or result never arrived). Consumes the result.
    task automatic run_op(input logic [7:0] xa, input logic [7:0] xb,
                          output logic [7:0] ry, output logic rovf, output logic runf,
                          output int lat);
        int waited;
        lat = -1;
        ry = 8'h00; rovf = 1'b0; runf = 1'b0;
        @(negedge clock);
        a = xa; b = xb; in_valid = 1'b1; out_ready = 1'b0;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) begin
                @(posedge clock); #1;
            end else begin
                @(posedge clock); #1;
            end
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) return;
        ry = y; rovf = ovf; runf = unf;
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bit seen;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 8'h00; b = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (y !== 8'h00) begin n_fail++; $display("FAIL reset_y got=%h exp=00", y); end
        n_checks++; if ({ovf, unf} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got=%b exp=00", {ovf, unf}); end
        @(negedge clock); reset = 1'b1;
        @(negedge clock); a = 8'h3C; b = 8'h3C; in_valid = 1'b1;
        @(posedge clock); #1; in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL busy_in_ready got=%b exp=0", in_ready); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_in_ready got=%b exp=1", in_ready); end
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
        seen = 1'b0;
        repeat (6) begin
            @(posedge clock); #1;
            if (out_valid) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_output got=%b exp=0", seen); end
    endtask

    task automatic test_basic();
        logic [7:0] ta [6] = '{8'h38, 8'h3C, 8'hB8, 8'h3D, 8'h77, 8'h08};
        logic [7:0] tb_ [6] = '{8'h38, 8'h3C, 8'h38, 8'h3D, 8'h77, 8'h08};
        logic [9:0] ex  [6];
        logic [7:0] ry; logic rovf, runf; int lat;
        ex[0] = 10'h038;
        ex[1] = 10'h041;
        ex[2] = 10'h0B8;
        ex[3] = RNE ? 10'h043 : 10'h042;
        ex[4] = 10'h27F;
        ex[5] = 10'h100;
        for (int i = 0; i < 6; i++) begin
            run_op(ta[i], tb_[i], ry, rovf, runf, lat);
            n_checks++;
            if ({rovf, runf, ry} !== ex[i])
                begin n_fail++; $display("FAIL directed_%0d %h*%h got={ovf,unf,y}=%h exp=%h", i, ta[i], tb_[i], {rovf, runf, ry}, ex[i]); end
            n_checks++;
            if (lat !== 3) begin n_fail++; $display("FAIL directed_latency_%0d got=%0d exp=3", i, lat); end
        end
        run_op(8'h80, 8'h3C, ry, rovf, runf, lat);
        n_checks++;
        if ({rovf, runf, ry} !== 10'h080)
            begin n_fail++; $display("FAIL zero_operand got=%h exp=080", {rovf, runf, ry}); end
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL zero_latency got=%0d exp=3", lat); end
    endtask

    task automatic test_random();
        logic [7:0] ra, rb, ry; logic rovf, runf; int lat; logic [9:0] ex;
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            ex = model(ra, rb);
            run_op(ra, rb, ry, rovf, runf, lat);
            n_checks++;
            if ({rovf, runf, ry} !== ex)
                begin n_fail++; $display("FAIL random_%0d %h*%h got=%h exp=%h", i, ra, rb, {rovf, runf, ry}, ex); end
            n_checks++;
            if (lat !== 3) begin n_fail++; $display("FAIL random_latency_%0d got=%0d exp=3", i, lat); end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clock);
        a = 8'h3C; b = 8'h3C; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clock); #1; in_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clock); #1;
            if (out_valid) begin lat = c; break; end
        end
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL bp_latency got=%0d exp=3", lat); end
        for (int c = 0; c < 6; c++) begin
            @(posedge clock); #1;
            n_checks++;
            if ({out_valid, in_ready, y} !== {1'b1, 1'b0, 8'h41})
                begin n_fail++; $display("FAIL bp_hold_%0d got={vld,rdy,y}=%b,%b,%h exp=1,0,41", c, out_valid, in_ready, y); end
        end
        @(negedge clock); out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01)
            begin n_fail++; $display("FAIL bp_release got={vld,rdy}=%b%b exp=01", out_valid, in_ready); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pa [4] = '{8'h3C, 8'h3D, 8'hC0, 8'h44};
        logic [7:0] pb [4] = '{8'h3C, 8'h3D, 8'h3A, 8'hB9};
        int idx, nout, last, first_acc;
        bit acc;
        idx = 0; nout = 0; last = 0; first_acc = -1;
        out_ready = 1'b1;
        for (int c = 0; c < 60 && nout < 4; c++) begin
            @(negedge clock);
            if (idx < 4) begin a = pa[idx]; b = pb[idx]; in_valid = 1'b1; end
            else in_valid = 1'b0;
            acc = in_ready && in_valid;
            @(posedge clock); #1;
            if (acc) begin
                if (first_acc < 0) first_acc = c;
                idx++;
            end
            if (out_valid) begin
                n_checks++;
                if ({ovf, unf, y} !== model(pa[nout], pb[nout]))
                    begin n_fail++; $display("FAIL b2b_value_%0d got=%h exp=%h", nout, {ovf, unf, y}, model(pa[nout], pb[nout])); end
                n_checks++;
                if (nout == 0) begin
                    if (c - first_acc !== 3) begin n_fail++; $display("FAIL b2b_first_latency got=%0d exp=3", c - first_acc); end
                end else if (c - last !== 5) begin
                    n_fail++; $display("FAIL b2b_spacing_%0d got=%0d exp=5", nout, c - last);
                end
                last = c;
                nout++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (nout !== 4) begin n_fail++; $display("FAIL b2b_count got=%0d exp=4", nout); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_backpressure();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
